// File: rtl/rev_pkg.sv
// Shared constants for the reversible full-adder decoder: in_vec field
// positions and the two-state collect/hold encoding.
package rev_pkg;

    localparam int GARB0 = 3;
    localparam int GARB1 = 2;
    localparam int SUM   = 1;
    localparam int COUT  = 0;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/rev_fa_inverse.sv
// Combinational inverse of one reversible full-adder slice: recovers a, b, cin
// and re-derives the carry to check it against the recorded cout.
module rev_fa_inverse
    import rev_pkg::*;
(
    input  logic [3:0] v,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       expCout,
    output logic       coutOk
);

    // garb1 carries a^b and sum carries a^b^c, so xor-ing peels them apart
    assign a       = v[GARB0];
    assign b       = v[GARB0] ^ v[GARB1];
    assign c       = v[GARB1] ^ v[SUM];
    assign expCout = (v[GARB1] & c) ^ (a & b);
    assign coutOk  = (v[COUT] == expCout);

endmodule

// File: rtl/rev_adder_decoder.sv
// Bit-serial decoder for the reversible adder chain: rebuilds A, B and cin
// LSB first, flags carry inconsistencies, and hands the word out on valid/ready.
module rev_adder_decoder
    import rev_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             cin_out,
    output logic             cout_out,
    output logic             err_cout,
    output logic             err_chain,
    output logic [IDXW-1:0]  err_idx
);

    state_t          state, stateNxt;
    logic [IDXW-1:0] bitCnt;
    logic            prevCout;
    logic            sa, sb, sc, expCout, coutOk;
    logic            accept, firstSlice, lastSlice;
    logic            coutMis, chainMis, anyPrev;

    rev_fa_inverse uInv (
        .v       (in_vec),
        .a       (sa),
        .b       (sb),
        .c       (sc),
        .expCout (expCout),
        .coutOk  (coutOk)
    );

    assign accept     = in_valid & in_ready;
    assign firstSlice = (bitCnt == '0);
    assign lastSlice  = (bitCnt == IDXW'(WIDTH - 1));
    assign coutMis    = ~coutOk;
    assign chainMis   = ~firstSlice & (sc != prevCout);
    // errors left over from the previous word must not suppress err_idx capture
    assign anyPrev    = ~firstSlice & (err_cout | err_chain);

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            COLLECT: if (accept && lastSlice) stateNxt = HOLD;
            HOLD:    if (out_ready)           stateNxt = COLLECT;
            default:                          stateNxt = COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt    <= '0;
            prevCout  <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            cin_out   <= 1'b0;
            cout_out  <= 1'b0;
            err_cout  <= 1'b0;
            err_chain <= 1'b0;
            err_idx   <= '0;
        end else if (accept) begin
            a_out[bitCnt] <= sa;
            b_out[bitCnt] <= sb;
            prevCout      <= in_vec[COUT];
            err_cout      <= (err_cout  & ~firstSlice) | coutMis;
            err_chain     <= (err_chain & ~firstSlice) | chainMis;
            if (firstSlice) begin
                cin_out <= sc;
                err_idx <= '0;
            end else if ((coutMis | chainMis) && !anyPrev) begin
                err_idx <= bitCnt;
            end
            if (lastSlice) begin
                cout_out <= in_vec[COUT];
                bitCnt   <= '0;
            end else begin
                bitCnt   <= bitCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rev_adder_decoder.sv
// Directed bench for rev_adder_decoder at WIDTH=4 with hand-encoded slice streams.
module tb_rev_adder_decoder;

    localparam int WIDTH = 4;
    localparam int IDXW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_out, b_out;
    logic             cin_out, cout_out, err_cout, err_chain;
    logic [IDXW-1:0]  err_idx;

    int nCmp = 0;
    int nErr = 0;

    rev_adder_decoder #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .cin_out   (cin_out),
        .cout_out  (cout_out),
        .err_cout  (err_cout),
        .err_chain (err_chain),
        .err_idx   (err_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendSlice(input logic [3:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        tick();
        in_valid = 1'b0;
        in_vec   = 4'h0;
    endtask

    task automatic sendWord(input logic [3:0] s0, s1, s2, s3);
        sendSlice(s0);
        sendSlice(s1);
        sendSlice(s2);
        sendSlice(s3);
    endtask

    task automatic checkWord(input string tag, input logic [3:0] a, b,
                             input logic ci, co, ec, ech, input logic [1:0] idx);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_a"},     a_out,     a);
        chk({tag, "_b"},     b_out,     b);
        chk({tag, "_cin"},   cin_out,   ci);
        chk({tag, "_cout"},  cout_out,  co);
        chk({tag, "_ecout"}, err_cout,  ec);
        chk({tag, "_echain"},err_chain, ech);
        chk({tag, "_eidx"},  err_idx,   idx);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = 4'h0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready,  1'b1);
        chk("rst_a",     a_out,     4'h0);
        chk("rst_b",     b_out,     4'h0);
        chk("rst_err",   {err_cout, err_chain, err_idx}, 4'h0);

        // 1: A=5, B=3, cin=0; out_valid directly after the 4th accepting edge
        sendSlice(4'b1001); sendSlice(4'b0101); sendSlice(4'b1101);
        chk("t1_early", out_valid, 1'b0);
        sendSlice(4'b0010);
        checkWord("t1", 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk("t1_drain", out_valid, 1'b0);

        // 2: slice 1 cout flipped -> cout error at 1, chain error at 2
        sendWord(4'b1001, 4'b0100, 4'b1101, 4'b0010);
        checkWord("t2", 4'h5, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        tick();

        // 3: 3 idle cycles between slices 1 and 2
        sendSlice(4'b1001); sendSlice(4'b0101);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_gap_valid", out_valid, 1'b0);
        end
        sendSlice(4'b1101); sendSlice(4'b0010);
        checkWord("t3", 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();

        // 4: hold an errored word with backpressure, junk offered meanwhile
        out_ready = 1'b0;
        sendWord(4'b1001, 4'b0100, 4'b1101, 4'b0010);
        in_valid = 1'b1; in_vec = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_ready", in_ready, 1'b0);
            checkWord("t4_hold", 4'h5, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0; in_vec = 4'h0;
        out_ready = 1'b1;
        tick();
        chk("t4_rel_ready", in_ready,  1'b1);
        chk("t4_rel_valid", out_valid, 1'b0);
        sendWord(4'b1001, 4'b0101, 4'b1101, 4'b0010);
        checkWord("t4_second", 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();

        // 5: reset after 2 junk slices, then a clean word
        sendSlice(4'b1111); sendSlice(4'b0110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_a",     a_out,    4'h0);
        chk("t5_rst_ready", in_ready, 1'b1);
        sendWord(4'b1001, 4'b0101, 4'b1101, 4'b0010);
        checkWord("t5", 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();

        // 6: A=F, B=1, cin=1; slice 0 (a=b=c=1) encodes as 1011
        sendWord(4'b1011, 4'b1101, 4'b1101, 4'b1101);
        checkWord("t6", 4'hF, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
